// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin arbiter that shares one UART transmitter among N byte sources.
// A grant is held across a multi-byte packet until the byte flagged 'last'
// has been sent. The start handshake is supervised: if tx_ready does not
// fall within TO_CYCLES of tx_start, the sticky err flag is raised and the
// grant is dropped so a dead transmitter cannot hang the requesters.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   req[N]    per-requester byte valid, held until acked
//   data[8N]  byte of requester i on data[8*i+7:8*i]
//   last[N]   current byte of requester i ends its packet
//   tx_ready  transmitter idle
//   tx_start  one-cycle start pulse to the transmitter
//   tx_din    byte to the transmitter, stable until the next issue
//   ack[N]    one-cycle pulse when requester i's byte is issued
//   grant[N]  one-hot current owner, zero when no owner
//   busy      FSM not in IDLE
//   err       sticky handshake timeout flag
module uart_tx_scheduler #(
    parameter int N         = 4,
    parameter int TO_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   data,
    input  logic [N-1:0]     last,
    input  logic             tx_ready,
    output logic             tx_start,
    output logic [7:0]       tx_din,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     grant,
    output logic             busy,
    output logic             err
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_WAIT_FALL,
        S_WAIT_RISE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic            r_last_q;
    logic [CW-1:0]   r_cnt;
    logic            r_tx_start;
    logic [7:0]      r_tx_din;
    logic [N-1:0]    r_ack;
    logic [N-1:0]    r_grant;
    logic            r_busy;
    logic            r_err;

    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_cand;
    logic [7:0]      w_sel_byte;
    logic [7:0]      w_own_byte;
    logic [N-1:0]    w_sel_oh;
    logic [N-1:0]    w_own_oh;

    // Round-robin search from ptr+1 upward. Scanning from the far end down
    // lets the last hit win, which is the nearest requester after ptr.
    always_comb begin
        w_sel  = '0;
        w_cand = '0;
        for (int k = N; k >= 1; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % N);
            if (req[w_cand]) w_sel = w_cand;
        end
    end

    always_comb begin
        w_sel_byte = '0;
        w_own_byte = '0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == w_sel)   w_sel_byte = data[8*i +: 8];
            if (IW'(i) == r_owner) w_own_byte = data[8*i +: 8];
        end
    end

    assign w_sel_oh = {{(N-1){1'b0}}, 1'b1} << w_sel;
    assign w_own_oh = {{(N-1){1'b0}}, 1'b1} << r_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= IW'(N - 1);
            r_owner    <= '0;
            r_last_q   <= 1'b0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_din   <= '0;
            r_ack      <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|req && tx_ready) begin
                        r_state <= S_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                // Outputs are registered, so the issue strobes are loaded on
                // the edge that enters ISSUE; they are visible during ISSUE.
                S_ARB: begin
                    if (|req) begin
                        r_owner    <= w_sel;
                        r_grant    <= w_sel_oh;
                        r_tx_start <= 1'b1;
                        r_tx_din   <= w_sel_byte;
                        r_ack      <= w_sel_oh;
                        r_last_q   <= last[w_sel];
                        r_cnt      <= '0;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                // The ISSUE cycle itself is the first cycle after tx_start.
                S_ISSUE: begin
                    r_cnt   <= CW'(1);
                    r_state <= S_WAIT_FALL;
                end
                S_WAIT_FALL: begin
                    if (!tx_ready) begin
                        r_state <= S_WAIT_RISE;
                    end else if (r_cnt == CW'(TO_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= r_owner;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_RISE: begin
                    if (tx_ready) begin
                        if (!r_last_q && req[r_owner]) begin
                            r_tx_start <= 1'b1;
                            r_tx_din   <= w_own_byte;
                            r_ack      <= w_own_oh;
                            r_last_q   <= last[r_owner];
                            r_cnt      <= '0;
                            r_state    <= S_ISSUE;
                        end else begin
                            // Packet complete, or abandoned by a late byte.
                            r_grant <= '0;
                            r_ptr   <= r_owner;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_din   = r_tx_din;
    assign ack      = r_ack;
    assign grant    = r_grant;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int N     = 4;
    localparam int TO    = 15;
    localparam int FRAME = 20;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic           tx_ready;
    logic           tx_start;
    logic [7:0]     tx_din;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           busy;
    logic           err;

    uart_tx_scheduler #(.N(N), .TO_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .data(data), .last(last),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_din(tx_din), .ack(ack),
        .grant(grant), .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Transmitter model: drops tx_ready two cycles after seeing start,
    // holds it low for FRAME cycles. When stuck it ignores start entirely.
    bit tx_stuck = 1'b0;
    int frames   = 0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start && !tx_stuck) begin
                @(negedge clk);
                @(negedge clk);
                tx_ready = 1'b0;
                repeat (FRAME) @(negedge clk);
                tx_ready = 1'b1;
                frames++;
            end
        end
    end

    // Requester engine: each requester walks its byte list, advancing on ack.
    // Bumping 'gen' rewinds every list to its start.
    logic [8:0] mem [N][16];
    int         len [N];
    int         gen = 0;
    initial begin
        int pos [N];
        int seen;
        bit fresh;
        seen = 0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        req  = '0;
        data = '0;
        last = '0;
        forever begin
            @(negedge clk);
            fresh = (gen != seen);
            for (int i = 0; i < N; i++) begin
                if (fresh) pos[i] = 0;
                else if (ack[i]) pos[i]++;
                if (pos[i] < len[i]) begin
                    req[i]          = 1'b1;
                    data[8*i +: 8]  = mem[i][pos[i]][7:0];
                    last[i]         = mem[i][pos[i]][8];
                end else begin
                    req[i] = 1'b0;
                end
            end
            seen = gen;
        end
    end

    int         iss_idx  [$];
    logic [7:0] iss_byte [$];

    // Behavioural model and per-cycle compare, sampled 1 time unit after
    // each rising edge. Tracks owner, round-robin pointer, cycles since the
    // last start and whether the transmitter has acknowledged the start.
    initial begin
        int   m_owner, m_ptr, m_k, m_phase, w;
        bit   m_err, m_last;
        logic [7:0] m_din;
        m_owner = -1; m_ptr = N - 1; m_err = 0; m_phase = 0; m_k = 0;
        m_last = 0; m_din = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                chk("reset_outputs", 32'({tx_start, tx_din, ack, grant, busy, err}), 32'(0));
                m_owner = -1; m_ptr = N - 1; m_err = 0; m_phase = 0; m_din = '0;
            end else begin
                chk("ack_onehot", 32'($countones(ack) <= 1), 32'(1));
                chk("ack_vs_grant", 32'(ack), 32'(tx_start ? grant : '0));
                if (m_owner < 0) begin
                    if (tx_start) begin
                        w = rr(m_ptr, req);
                        chk("rr_has_winner", 32'(w >= 0), 32'(1));
                        if (w >= 0) begin
                            chk("rr_winner_ack", 32'(ack), 32'(1) << w);
                            chk("new_din", 32'(tx_din), 32'(data[8*w +: 8]));
                            m_owner = w; m_last = last[w]; m_din = data[8*w +: 8];
                            m_k = 0; m_phase = 1;
                        end
                        iss_idx.push_back(idx_of(ack));
                        iss_byte.push_back(tx_din);
                    end else begin
                        chk("din_hold_idle", 32'(tx_din), 32'(m_din));
                    end
                end else if (m_phase == 1) begin
                    m_k++;
                    chk("no_start_wait_fall", 32'(tx_start), 32'(0));
                    chk("din_hold_fall", 32'(tx_din), 32'(m_din));
                    if (m_k >= 2 && !tx_ready) begin
                        m_phase = 2;
                    end else if (m_k == TO) begin
                        m_err = 1; m_ptr = m_owner; m_owner = -1; m_phase = 0;
                    end
                end else begin
                    if (tx_ready && !m_last && req[m_owner]) begin
                        chk("cont_start", 32'(tx_start), 32'(1));
                        chk("cont_din", 32'(tx_din), 32'(data[8*m_owner +: 8]));
                        m_last = last[m_owner]; m_din = data[8*m_owner +: 8];
                        m_k = 0; m_phase = 1;
                        iss_idx.push_back(idx_of(ack));
                        iss_byte.push_back(tx_din);
                    end else begin
                        chk("no_start_wait_rise", 32'(tx_start), 32'(0));
                        chk("din_hold_rise", 32'(tx_din), 32'(m_din));
                        if (tx_ready) begin
                            m_ptr = m_owner; m_owner = -1; m_phase = 0;
                        end
                    end
                end
                chk("grant", 32'(grant), (m_owner >= 0) ? (32'(1) << m_owner) : 32'(0));
                chk("err", 32'(err), 32'(m_err));
                if (m_owner >= 0) chk("busy_owned", 32'(busy), 32'(1));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cyc(2);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic put(input int i, input int p, input logic lb, input logic [7:0] b);
        mem[i][p] = {lb, b};
    endtask

    task automatic wait_issued(input int n, input int limit, input string name);
        int c;
        c = 0;
        while (iss_idx.size() < n && c < limit) begin
            cyc(1);
            c++;
        end
        chk(name, 32'(iss_idx.size() >= n), 32'(1));
    endtask

    task automatic wait_idle(input int limit, input string name);
        int c;
        c = 0;
        while ((busy || !tx_ready) && c < limit) begin
            cyc(1);
            c++;
        end
        chk(name, 32'(!busy && tx_ready), 32'(1));
    endtask

    initial begin
        int base, f0, n;
        int ord5 [5];
        int ord4 [4];
        ord5 = '{0, 1, 2, 3, 0};
        ord4 = '{0, 1, 2, 3};
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) len[i] = 0;

        // Single byte, latency and reset state
        do_reset();
        chk("rst_state", 32'({tx_start, tx_din, ack, grant, busy, err}), 32'(0));
        base = iss_idx.size();
        f0   = frames;
        put(0, 0, 1'b1, 8'hA5);
        len = '{1, 0, 0, 0};
        gen++;
        cyc(1);
        chk("single_arb_no_start", 32'(tx_start), 32'(0));
        chk("single_arb_busy", 32'(busy), 32'(1));
        cyc(1);
        chk("single_start_c2", 32'(tx_start), 32'(1));
        chk("single_ack_c2", 32'(ack), 32'(4'b0001));
        chk("single_din", 32'(tx_din), 32'(8'hA5));
        chk("single_grant", 32'(grant), 32'(4'b0001));
        wait_idle(200, "single_idle");
        chk("single_frames", 32'(frames - f0), 32'(1));
        chk("single_grant_rel", 32'(grant), 32'(0));
        chk("single_issued", 32'(iss_idx.size() - base), 32'(1));

        // Contention with single-byte packets, then reset mid-sequence
        do_reset();
        base = iss_idx.size();
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 3; p++) put(i, p, 1'b1, 8'(8'h20 + i * 4 + p));
        len = '{3, 3, 3, 3};
        gen++;
        wait_issued(base + 5, 600, "cont_issued5");
        for (int k = 0; k < 5; k++)
            if (iss_idx.size() > base + k) chk("cont_order", 32'(iss_idx[base + k]), 32'(ord5[k]));
        cyc(3);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        len = '{2, 2, 2, 2};
        gen++;
        cyc(1);
        @(negedge clk);
        reset_n = 1'b1;
        base = iss_idx.size();
        wait_issued(base + 4, 600, "cont_restart_issued");
        for (int k = 0; k < 4; k++)
            if (iss_idx.size() > base + k) chk("cont_restart_order", 32'(iss_idx[base + k]), 32'(ord4[k]));
        wait_idle(600, "cont_idle");

        // Packet lock: requester 2 sends three bytes while requester 1 waits
        do_reset();
        base = iss_idx.size();
        put(2, 0, 1'b0, 8'h10);
        put(2, 1, 1'b0, 8'h11);
        put(2, 2, 1'b1, 8'h12);
        put(1, 0, 1'b1, 8'h31);
        len = '{0, 0, 3, 0};
        gen++;
        wait_issued(base + 1, 50, "lock_first");
        len[1] = 1;
        wait_issued(base + 4, 400, "lock_all");
        if (iss_idx.size() >= base + 4) begin
            chk("lock_idx0", 32'(iss_idx[base]),      32'(2));
            chk("lock_idx1", 32'(iss_idx[base + 1]),  32'(2));
            chk("lock_idx2", 32'(iss_idx[base + 2]),  32'(2));
            chk("lock_idx3", 32'(iss_idx[base + 3]),  32'(1));
            chk("lock_b0", 32'(iss_byte[base]),     32'(8'h10));
            chk("lock_b1", 32'(iss_byte[base + 1]), 32'(8'h11));
            chk("lock_b2", 32'(iss_byte[base + 2]), 32'(8'h12));
            chk("lock_b3", 32'(iss_byte[base + 3]), 32'(8'h31));
        end
        wait_idle(200, "lock_idle");

        // Timeout with a transmitter that ignores start
        do_reset();
        tx_stuck = 1'b1;
        base = iss_idx.size();
        put(3, 0, 1'b1, 8'h3C);
        put(0, 0, 1'b1, 8'h0F);
        len = '{0, 0, 0, 1};
        gen++;
        n = 0;
        while (!tx_start && n < 50) begin
            cyc(1);
            n++;
        end
        chk("to_start_seen", 32'(tx_start), 32'(1));
        n = 0;
        while (!err && n < 40) begin
            cyc(1);
            n++;
        end
        chk("to_latency", 32'(n), 32'(15));
        chk("to_err", 32'(err), 32'(1));
        chk("to_grant", 32'(grant), 32'(0));
        tx_stuck = 1'b0;
        len[0] = 1;
        wait_issued(base + 2, 100, "to_next_served");
        if (iss_idx.size() >= base + 2) begin
            chk("to_next_idx", 32'(iss_idx[base + 1]), 32'(0));
            chk("to_next_byte", 32'(iss_byte[base + 1]), 32'(8'h0F));
        end
        wait_idle(200, "to_idle");
        chk("to_err_sticky", 32'(err), 32'(1));

        // Abandoned packet: requester 1 drops req after a non-last byte
        do_reset();
        base = iss_idx.size();
        put(1, 0, 1'b0, 8'h55);
        put(1, 1, 1'b1, 8'h66);
        put(2, 0, 1'b1, 8'h77);
        len = '{0, 1, 0, 0};
        gen++;
        wait_issued(base + 1, 50, "aband_first");
        wait_idle(200, "aband_idle");
        cyc(10);
        chk("aband_no_resend", 32'(iss_idx.size() - base), 32'(1));
        chk("aband_grant", 32'(grant), 32'(0));
        len[1] = 2;
        len[2] = 1;
        wait_issued(base + 3, 300, "aband_next");
        if (iss_idx.size() >= base + 3) begin
            chk("aband_ptr_2_first", 32'(iss_idx[base + 1]), 32'(2));
            chk("aband_then_1", 32'(iss_idx[base + 2]), 32'(1));
        end
        wait_idle(200, "aband_idle2");

        // Asynchronous reset while waiting for tx_ready to rise
        do_reset();
        base = iss_idx.size();
        put(0, 0, 1'b1, 8'hC3);
        put(2, 0, 1'b1, 8'h99);
        len = '{1, 0, 0, 0};
        gen++;
        wait_issued(base + 1, 50, "ar_first");
        n = 0;
        while (tx_ready && n < 20) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk("ar_in_flight_grant", 32'(grant), 32'(4'b0001));
        chk("ar_in_flight_busy", 32'(busy), 32'(1));
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_async_clear", 32'({tx_start, tx_din, ack, grant, busy, err}), 32'(0));
        cyc(1);
        @(negedge clk);
        reset_n = 1'b1;
        wait_idle(200, "ar_idle");
        cyc(10);
        chk("ar_no_resend", 32'(iss_idx.size() - base), 32'(1));
        len[2] = 1;
        wait_issued(base + 2, 50, "ar_restart");
        if (iss_idx.size() >= base + 2) begin
            chk("ar_restart_idx", 32'(iss_idx[base + 1]), 32'(2));
            chk("ar_restart_byte", 32'(iss_byte[base + 1]), 32'(8'h99));
        end
        wait_idle(200, "ar_idle2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
